// File: rtl/binarize_thr_ctrl.sv
// Per-frame adaptive threshold for the binarizer: averages frame luminance,
// applies a signed offset and clamp, and publishes during vertical blanking.
module binarize_thr_ctrl #(
  parameter int         CNT_W   = 21,
  parameter int         SUM_W   = 29,
  parameter logic [7:0] THR_DEF = 8'd64,
  parameter logic [7:0] THR_MIN = 8'd16,
  parameter logic [7:0] THR_MAX = 8'd240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_de,
  input  logic [7:0] color,
  input  logic       manual_en,
  input  logic [7:0] manual_thr,
  input  logic [7:0] thr_offset,
  output logic [7:0] threshold,
  output logic       thr_valid,
  output logic       busy,
  output logic       empty_frame,
  output logic       overrun
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_APPLY} state_t;

  localparam logic signed [9:0] MIN10 = {2'b00, THR_MIN};
  localparam logic signed [9:0] MAX10 = {2'b00, THR_MAX};

  state_t             state, state_nxt;
  logic               vsync_q;
  logic               start;
  logic               frame_end;
  logic               in_flight;
  logic [SUM_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   acc_cnt;
  logic [SUM_W:0]     sum_add;
  logic [SUM_W-1:0]   sum_sat;
  logic [CNT_W-1:0]   cnt_inc;
  logic [SUM_W-1:0]   div_rem;
  logic [CNT_W-1:0]   div_cnt;
  logic [SUM_W-1:0]   trial;
  logic               rem_ge;
  logic [2:0]         bit_idx;
  logic [7:0]         quot;
  logic signed [9:0]  t_sum;
  logic [7:0]         t_auto;
  logic [7:0]         t_apply;
  logic               empty_now;

  assign frame_end = pre_frame_vsync & ~vsync_q;
  assign busy      = (state != S_IDLE);
  // a snapshot taken but not yet picked up by the FSM also blocks a new one
  assign in_flight = busy | start;

  // saturating accumulators: never wrap on oversized frames
  assign sum_add = {1'b0, acc_sum} + {{(SUM_W-7){1'b0}}, color};
  assign sum_sat = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
  assign cnt_inc = (&acc_cnt) ? acc_cnt : acc_cnt + 1'b1;

  // restoring divider step; cnt<<7 always fits in SUM_W bits
  assign trial  = SUM_W'(div_cnt) << bit_idx;
  assign rem_ge = (div_rem >= trial);

  always_comb begin
    t_sum = $signed({2'b00, quot}) + $signed({{2{thr_offset[7]}}, thr_offset});
    if (t_sum < MIN10)      t_auto = THR_MIN;
    else if (t_sum > MAX10) t_auto = THR_MAX;
    else                    t_auto = t_sum[7:0];
  end

  always_comb begin
    empty_now = 1'b0;
    t_apply   = t_auto;
    if (manual_en) begin
      t_apply = manual_thr;
    end else if (div_cnt == '0) begin
      t_apply   = threshold;
      empty_now = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DIV;
      S_DIV:   if (bit_idx == 3'd0) state_nxt = S_APPLY;
      S_APPLY: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      start       <= 1'b0;
      acc_sum     <= '0;
      acc_cnt     <= '0;
      div_rem     <= '0;
      div_cnt     <= '0;
      bit_idx     <= 3'd0;
      quot        <= 8'd0;
      threshold   <= THR_DEF;
      thr_valid   <= 1'b0;
      empty_frame <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      vsync_q     <= pre_frame_vsync;
      start       <= 1'b0;
      thr_valid   <= 1'b0;
      empty_frame <= 1'b0;

      // a pixel on the frame-end cycle belongs to the next frame
      if (frame_end) begin
        acc_sum <= pre_frame_de ? SUM_W'(color) : '0;
        acc_cnt <= pre_frame_de ? CNT_W'(1) : '0;
        if (in_flight) begin
          overrun <= 1'b1;
        end else begin
          div_rem <= acc_sum;
          div_cnt <= acc_cnt;
          start   <= 1'b1;
        end
      end else if (pre_frame_de) begin
        acc_sum <= sum_sat;
        acc_cnt <= cnt_inc;
      end

      if (start) begin
        bit_idx <= 3'd7;
        quot    <= 8'd0;
      end

      if (state == S_DIV) begin
        if (rem_ge) begin
          div_rem       <= div_rem - trial;
          quot[bit_idx] <= 1'b1;
        end
        bit_idx <= bit_idx - 3'd1;
      end

      if (state == S_APPLY) begin
        threshold   <= t_apply;
        thr_valid   <= 1'b1;
        empty_frame <= empty_now;
      end
    end
  end

endmodule

// File: tb/tb_binarize_thr_ctrl.sv
// Directed bench for binarize_thr_ctrl: expected thresholds are queued at each
// frame end and checked by a monitor when thr_valid pulses.
module tb_binarize_thr_ctrl;

  typedef struct {
    logic [7:0] thr;
    logic       empty;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       pre_frame_vsync;
  logic       pre_frame_de;
  logic [7:0] color;
  logic       manual_en;
  logic [7:0] manual_thr;
  logic [7:0] thr_offset;
  logic [7:0] threshold;
  logic       thr_valid;
  logic       busy;
  logic       empty_frame;
  logic       overrun;

  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  binarize_thr_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .pre_frame_vsync (pre_frame_vsync),
    .pre_frame_de    (pre_frame_de),
    .color           (color),
    .manual_en       (manual_en),
    .manual_thr      (manual_thr),
    .thr_offset      (thr_offset),
    .threshold       (threshold),
    .thr_valid       (thr_valid),
    .busy            (busy),
    .empty_frame     (empty_frame),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // scoreboard consumer: every thr_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (thr_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_thr_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_threshold", int'(threshold), int'(e.thr));
        chk("sb_empty_frame", int'(empty_frame), int'(e.empty));
      end
    end else if (empty_frame) begin
      chk("empty_without_valid", 1, 0);
    end
  end

  task automatic pix(input int n, input logic [7:0] c);
    repeat (n) begin
      @(negedge clk);
      pre_frame_de = 1'b1;
      color        = c;
    end
    @(negedge clk);
    pre_frame_de = 1'b0;
    color        = 8'd0;
  endtask

  // raise vsync, then walk E..E+10 checking busy and the thr_valid slot
  task automatic frame_end(input string tag, input logic [7:0] thr, input logic empty);
    exp_t e;
    e.thr   = thr;
    e.empty = empty;
    sb.push_back(e);
    @(negedge clk);
    pre_frame_vsync = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk({tag, "_busy"}, int'(busy), (k >= 1 && k <= 9) ? 1 : 0);
      chk({tag, "_valid_slot"}, int'(thr_valid), (k == 10) ? 1 : 0);
    end
    pre_frame_vsync = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pre_frame_vsync = 1'b0; pre_frame_de = 1'b0; color = 8'd0;
    manual_en = 1'b0; manual_thr = 8'd0; thr_offset = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_threshold", int'(threshold), 64);
    chk("rst_thr_valid", int'(thr_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_empty", int'(empty_frame), 0);
    chk("rst_overrun", int'(overrun), 0);

    // flat frame of 100
    pix(16, 8'd100);
    frame_end("t1", 8'd100, 1'b0);

    // mean 100, offset -20
    thr_offset = 8'hEC;
    pix(8, 8'd200);
    pix(8, 8'd0);
    frame_end("t2", 8'd80, 1'b0);

    // clamps
    thr_offset = 8'd20;
    pix(16, 8'd250);
    frame_end("t3_max", 8'd240, 1'b0);
    thr_offset = 8'hEC;
    pix(16, 8'd10);
    frame_end("t3_min", 8'd16, 1'b0);

    // empty frame keeps the prior value
    thr_offset = 8'd0;
    repeat (5) @(negedge clk);
    frame_end("t4", 8'd16, 1'b1);

    // manual toggles mid-frame must not disturb the published value
    pix(4, 8'd100);
    manual_thr = 8'd5;
    manual_en  = 1'b1;
    @(negedge clk);
    chk("t5_hold_a", int'(threshold), 16);
    manual_en = 1'b0;
    pix(4, 8'd100);
    manual_en = 1'b1;
    @(negedge clk);
    chk("t5_hold_b", int'(threshold), 16);
    frame_end("t5", 8'd5, 1'b0);
    manual_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_hold_after", int'(threshold), 5);

    // second vsync rise while dividing
    begin
      exp_t e;
      e.thr = 8'd100; e.empty = 1'b0;
      pix(16, 8'd100);
      sb.push_back(e);
      @(negedge clk);
      pre_frame_vsync = 1'b1;
      @(negedge clk);              // after E
      pre_frame_vsync = 1'b0;
      repeat (3) @(negedge clk);   // after E+3
      pre_frame_vsync = 1'b1;
      @(negedge clk);              // after E+4
      chk("t6_overrun", int'(overrun), 1);
      chk("t6_busy", int'(busy), 1);
      repeat (5) @(negedge clk);   // after E+9
      chk("t6_not_yet", int'(thr_valid), 0);
      @(negedge clk);              // after E+10
      chk("t6_valid", int'(thr_valid), 1);
      repeat (3) @(negedge clk);
      chk("t6_sticky", int'(overrun), 1);
    end

    // reset in the middle of a division
    pre_frame_vsync = 1'b0;
    pix(8, 8'd200);
    @(negedge clk);
    pre_frame_vsync = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_div_busy", int'(busy), 1);
    rst = 1'b1;
    pre_frame_vsync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_threshold", int'(threshold), 64);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_overrun", int'(overrun), 0);
    begin
      int pulses = 0;
      repeat (14) begin
        @(negedge clk);
        if (thr_valid) pulses++;
      end
      chk("t6_rst_no_valid", pulses, 0);
    end
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
